// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
// Multi-write-port register file for the decode stage. It has a same-cycle
// write-through bypass and a per-register pending-write scoreboard, so issue
// logic can stall on RAW hazards.
//
// Parameters
//   DATA_W    register data width
//   ADDR_W    register address width (NREG = 2**ADDR_W)
//   ZERO_REG  1 = register 0 reads as zero, is never written, never busy
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   ra_addr / ra_data / ra_busy  read port A (combinational data + busy)
//   rb_addr / rb_data / rb_busy  read port B (combinational data + busy)
//   w0_en / w0_addr / w0_data    write port 0 (writeback, wins on collision)
//   w1_en / w1_addr / w1_data    write port 1 (load return)
//   iss_en / iss_addr            mark destination register pending
//   flush                        clear every pending bit
//   pend_cnt                     registered count of pending registers
// ----------------------------------------------------------------------------
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] ra_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic              ra_busy,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] rb_data,
   output logic              rb_busy,
   input  logic              w0_en,
   input  logic [ADDR_W-1:0] w0_addr,
   input  logic [DATA_W-1:0] w0_data,
   input  logic              w1_en,
   input  logic [ADDR_W-1:0] w1_addr,
   input  logic [DATA_W-1:0] w1_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              flush,
   output logic [ADDR_W:0]   pend_cnt
);

   localparam int NREG = 1 << ADDR_W;

   // An address is writable/trackable unless it is the hardwired zero register.
   function automatic logic addr_legal(input logic [ADDR_W-1:0] addr);
      logic ok;
      if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

   // Number of set bits in a busy vector; width covers 0..NREG inclusive.
   function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] vec);
      logic [ADDR_W:0] cnt;
      cnt = {(ADDR_W+1){1'b0}};
      for (int i = 0; i < NREG; i++) begin
         cnt = cnt + {{ADDR_W{1'b0}}, vec[i]};
      end
      return cnt;
   endfunction

   logic [DATA_W-1:0] mem_q [NREG];
   logic [NREG-1:0]   busy_q;
   logic [NREG-1:0]   busy_d;
   logic [ADDR_W:0]   pend_cnt_q;
   logic [ADDR_W:0]   pend_cnt_d;

   logic w0_ok_s;
   logic w1_ok_s;
   logic iss_ok_s;
   logic ra_w0_hit_s;
   logic ra_w1_hit_s;
   logic rb_w0_hit_s;
   logic rb_w1_hit_s;

   // Qualify each request with its address legality once, for all consumers.
   always_comb begin
      w0_ok_s  = w0_en  & addr_legal(w0_addr);
      w1_ok_s  = w1_en  & addr_legal(w1_addr);
      iss_ok_s = iss_en & addr_legal(iss_addr);
   end

   // Per-port bypass hit detection; each port decodes only its own address.
   always_comb begin
      ra_w0_hit_s = w0_ok_s & (w0_addr == ra_addr);
      ra_w1_hit_s = w1_ok_s & (w1_addr == ra_addr);
      rb_w0_hit_s = w0_ok_s & (w0_addr == rb_addr);
      rb_w1_hit_s = w1_ok_s & (w1_addr == rb_addr);
   end

   // Read port A: zero register, then w0 bypass, then w1 bypass, then array.
   always_comb begin
      ra_data = {DATA_W{1'b0}};
      ra_busy = 1'b0;
      if (!addr_legal(ra_addr)) begin
         ra_data = {DATA_W{1'b0}};
         ra_busy = 1'b0;
      end else if (ra_w0_hit_s) begin
         ra_data = w0_data;
         ra_busy = 1'b0;
      end else if (ra_w1_hit_s) begin
         ra_data = w1_data;
         ra_busy = 1'b0;
      end else begin
         ra_data = mem_q[ra_addr];
         ra_busy = busy_q[ra_addr];
      end
   end

   // Read port B: same priority as port A, driven only by rb_addr.
   always_comb begin
      rb_data = {DATA_W{1'b0}};
      rb_busy = 1'b0;
      if (!addr_legal(rb_addr)) begin
         rb_data = {DATA_W{1'b0}};
         rb_busy = 1'b0;
      end else if (rb_w0_hit_s) begin
         rb_data = w0_data;
         rb_busy = 1'b0;
      end else if (rb_w1_hit_s) begin
         rb_data = w1_data;
         rb_busy = 1'b0;
      end else begin
         rb_data = mem_q[rb_addr];
         rb_busy = busy_q[rb_addr];
      end
   end

   // Scoreboard next state: flush beats issue, issue beats a write clear.
   always_comb begin
      busy_d = busy_q;
      if (flush) begin
         busy_d = {NREG{1'b0}};
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (iss_ok_s && (iss_addr == ADDR_W'(i))) begin
               busy_d[i] = 1'b1;
            end else if ((w0_ok_s && (w0_addr == ADDR_W'(i))) ||
                         (w1_ok_s && (w1_addr == ADDR_W'(i)))) begin
               busy_d[i] = 1'b0;
            end else begin
               busy_d[i] = busy_q[i];
            end
         end
      end
      // Counting the next vector keeps pend_cnt aligned with busy_q.
      pend_cnt_d = popcount(busy_d);
   end

   // Scoreboard and pending-count registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q     <= {NREG{1'b0}};
         pend_cnt_q <= {(ADDR_W+1){1'b0}};
      end else begin
         busy_q     <= busy_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   // Register array; w1 is written first so a colliding w0 overrides it.
   // Writes commit regardless of flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         if (w1_ok_s) begin
            mem_q[w1_addr] <= w1_data;
         end
         if (w0_ok_s) begin
            mem_q[w0_addr] <= w0_data;
         end
      end
   end

   assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
// Directed bench for regfile_sb. The driver applies inputs shortly after the
// rising edge and pushes the hand-computed expected outputs into a scoreboard
// queue. A monitor on the falling edge pops and compares every queued entry.
// ----------------------------------------------------------------------------
module tb_regfile_sb;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   localparam int K_RA_DATA = 0;
   localparam int K_RA_BUSY = 1;
   localparam int K_RB_DATA = 2;
   localparam int K_RB_BUSY = 3;
   localparam int K_PEND    = 4;

   logic              clk;
   logic              reset_n;
   logic [ADDR_W-1:0] ra_addr;
   logic [DATA_W-1:0] ra_data;
   logic              ra_busy;
   logic [ADDR_W-1:0] rb_addr;
   logic [DATA_W-1:0] rb_data;
   logic              rb_busy;
   logic              w0_en;
   logic [ADDR_W-1:0] w0_addr;
   logic [DATA_W-1:0] w0_data;
   logic              w1_en;
   logic [ADDR_W-1:0] w1_addr;
   logic [DATA_W-1:0] w1_data;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;
   logic              flush;
   logic [ADDR_W:0]   pend_cnt;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .ra_addr  (ra_addr),
      .ra_data  (ra_data),
      .ra_busy  (ra_busy),
      .rb_addr  (rb_addr),
      .rb_data  (rb_data),
      .rb_busy  (rb_busy),
      .w0_en    (w0_en),
      .w0_addr  (w0_addr),
      .w0_data  (w0_data),
      .w1_en    (w1_en),
      .w1_addr  (w1_addr),
      .w1_data  (w1_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .flush    (flush),
      .pend_cnt (pend_cnt)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: drain the scoreboard against the DUT outputs on the falling edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] act;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.kind)
            K_RA_DATA: act = ra_data;
            K_RA_BUSY: act = {31'd0, ra_busy};
            K_RB_DATA: act = rb_data;
            K_RB_BUSY: act = {31'd0, rb_busy};
            K_PEND:    act = {26'd0, pend_cnt};
            default:   act = 32'hxxxx_xxxx;
         endcase
         n_checks++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                     e.name, act, e.exp, $time);
         end
      end
   end

   task automatic chk(input string name, input int kind, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = val;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      w0_en    = 1'b0;
      w0_addr  = 5'd0;
      w0_data  = 32'd0;
      w1_en    = 1'b0;
      w1_addr  = 5'd0;
      w1_data  = 32'd0;
      iss_en   = 1'b0;
      iss_addr = 5'd0;
      flush    = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      ra_addr = 5'd0;
      rb_addr = 5'd0;
      idle();
      step();
      step();

      // During reset.
      ra_addr = 5'd5;
      rb_addr = 5'd9;
      chk("rst_pend", K_PEND, 32'd0);
      chk("rst_ra_data", K_RA_DATA, 32'd0);
      chk("rst_rb_busy", K_RB_BUSY, 32'd0);
      step();
      reset_n = 1'b1;

      // Every address on both ports reads zero and idle after reset.
      for (int a = 0; a < 32; a++) begin
         ra_addr = 5'(a);
         rb_addr = 5'(31 - a);
         chk("sweep_ra_data", K_RA_DATA, 32'd0);
         chk("sweep_ra_busy", K_RA_BUSY, 32'd0);
         chk("sweep_rb_data", K_RB_DATA, 32'd0);
         chk("sweep_rb_busy", K_RB_BUSY, 32'd0);
         chk("sweep_pend", K_PEND, 32'd0);
         step();
      end

      // w0 bypass, then array read with independent port decode.
      w0_en = 1'b1; w0_addr = 5'd5; w0_data = 32'hDEAD_BEEF;
      ra_addr = 5'd5;
      chk("w0_bypass_r5", K_RA_DATA, 32'hDEAD_BEEF);
      step();
      idle();
      ra_addr = 5'd3; rb_addr = 5'd5;
      chk("rb_array_r5", K_RB_DATA, 32'hDEAD_BEEF);
      chk("ra_indep_r3", K_RA_DATA, 32'd0);
      step();

      // w0/w1 collision: w0 wins in bypass and in storage.
      w0_en = 1'b1; w0_addr = 5'd7; w0_data = 32'h1111_1111;
      w1_en = 1'b1; w1_addr = 5'd7; w1_data = 32'h2222_2222;
      ra_addr = 5'd7; rb_addr = 5'd7;
      chk("coll_bypass_ra", K_RA_DATA, 32'h1111_1111);
      chk("coll_bypass_rb", K_RB_DATA, 32'h1111_1111);
      step();
      idle();
      chk("coll_stored", K_RA_DATA, 32'h1111_1111);
      // Write to r0 is ignored and r0 reads zero.
      w0_en = 1'b1; w0_addr = 5'd0; w0_data = 32'hFFFF_FFFF;
      rb_addr = 5'd0;
      chk("r0_bypass", K_RB_DATA, 32'd0);
      step();
      idle();
      ra_addr = 5'd0;
      // w1 alone bypasses too.
      w1_en = 1'b1; w1_addr = 5'd8; w1_data = 32'h0000_0033;
      rb_addr = 5'd8;
      chk("r0_stored", K_RA_DATA, 32'd0);
      chk("w1_bypass_r8", K_RB_DATA, 32'h0000_0033);
      step();
      idle();

      // Issue r9: same-cycle issue does not raise busy.
      iss_en = 1'b1; iss_addr = 5'd9;
      ra_addr = 5'd9;
      chk("iss_same_busy", K_RA_BUSY, 32'd0);
      chk("iss_same_pend", K_PEND, 32'd0);
      step();
      idle();
      chk("iss_r9_busy", K_RA_BUSY, 32'd1);
      chk("iss_r9_pend", K_PEND, 32'd1);
      step();
      // w1 writeback clears busy in the same cycle via bypass.
      w1_en = 1'b1; w1_addr = 5'd9; w1_data = 32'h0000_ABCD;
      chk("wb_r9_busy", K_RA_BUSY, 32'd0);
      chk("wb_r9_data", K_RA_DATA, 32'h0000_ABCD);
      chk("wb_r9_pend_before", K_PEND, 32'd1);
      step();
      idle();
      chk("wb_r9_pend_after", K_PEND, 32'd0);
      chk("wb_r9_stored", K_RA_DATA, 32'h0000_ABCD);
      step();

      // Issue overrides a same-cycle write clear.
      iss_en = 1'b1; iss_addr = 5'd4;
      w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'h0000_0044;
      ra_addr = 5'd4;
      chk("iss_wr_r4_data", K_RA_DATA, 32'h0000_0044);
      step();
      idle();
      chk("iss_wr_r4_busy", K_RA_BUSY, 32'd1);
      chk("iss_wr_r4_pend", K_PEND, 32'd1);
      // Issuing r0 changes nothing.
      iss_en = 1'b1; iss_addr = 5'd0;
      rb_addr = 5'd0;
      step();
      idle();
      chk("iss_r0_busy", K_RB_BUSY, 32'd0);
      chk("iss_r0_pend", K_PEND, 32'd1);
      // Clear r4.
      w0_en = 1'b1; w0_addr = 5'd4; w0_data = 32'h0000_0045;
      chk("clr_r4_busy", K_RA_BUSY, 32'd0);
      step();
      idle();
      chk("clr_r4_pend", K_PEND, 32'd0);
      step();

      // Issue r1..r31.
      for (int i = 1; i < 32; i++) begin
         iss_en = 1'b1; iss_addr = 5'(i);
         step();
      end
      idle();
      ra_addr = 5'd1; rb_addr = 5'd31;
      chk("full_pend", K_PEND, 32'd31);
      chk("full_r1_busy", K_RA_BUSY, 32'd1);
      chk("full_r31_busy", K_RB_BUSY, 32'd1);
      step();
      // Flush with a concurrent write.
      flush = 1'b1;
      w0_en = 1'b1; w0_addr = 5'd2; w0_data = 32'h0000_0055;
      ra_addr = 5'd2; rb_addr = 5'd3;
      chk("flush_r2_data", K_RA_DATA, 32'h0000_0055);
      chk("flush_r2_busy", K_RA_BUSY, 32'd0);
      chk("flush_r3_busy_before", K_RB_BUSY, 32'd1);
      chk("flush_pend_before", K_PEND, 32'd31);
      step();
      idle();
      chk("flush_pend_after", K_PEND, 32'd0);
      chk("flush_r2_stored", K_RA_DATA, 32'h0000_0055);
      chk("flush_r2_busy_after", K_RA_BUSY, 32'd0);
      chk("flush_r3_busy_after", K_RB_BUSY, 32'd0);
      step();

      // Repeat partially, then reset mid-sequence.
      for (int i = 1; i <= 10; i++) begin
         iss_en = 1'b1; iss_addr = 5'(i);
         step();
      end
      idle();
      ra_addr = 5'd5;
      chk("rep_pend", K_PEND, 32'd10);
      chk("rep_r5_busy", K_RA_BUSY, 32'd1);
      step();
      iss_en = 1'b1; iss_addr = 5'd11;
      reset_n = 1'b0;
      ra_addr = 5'd5; rb_addr = 5'd2;
      chk("arst_pend", K_PEND, 32'd0);
      chk("arst_r5_data", K_RA_DATA, 32'd0);
      chk("arst_r5_busy", K_RA_BUSY, 32'd0);
      chk("arst_r2_data", K_RB_DATA, 32'd0);
      step();
      idle();
      chk("arst_hold_pend", K_PEND, 32'd0);
      step();
      // First edge after deassertion accepts a write.
      reset_n = 1'b1;
      w0_en = 1'b1; w0_addr = 5'd6; w0_data = 32'h0000_0066;
      step();
      idle();
      ra_addr = 5'd6; rb_addr = 5'd5;
      chk("post_rst_r6", K_RA_DATA, 32'h0000_0066);
      chk("post_rst_r5", K_RB_DATA, 32'd0);
      chk("post_rst_pend", K_PEND, 32'd0);
      step();
      step();

      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
